// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, error codes and PS/2 command bytes for the host transmitter.
package ps2_pkg;
    typedef enum logic [2:0] {IDLE, INHIBIT, WAIT_START, SHIFT, ACK, FINISH, FAIL} state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_NACK     = 2'd1;
    localparam logic [1:0] ERR_START_TO = 2'd2;
    localparam logic [1:0] ERR_XFER_TO  = 2'd3;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESEND   = 8'hFE;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchronizer plus stability filter with a registered falling-edge strobe.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic fall
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

    logic [1:0] sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= 2'b11;
            level <= 1'b1;
            fall  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync <= {sync[0], raw};
            fall <= 1'b0;
            if (sync[1] == level)
                cnt <= '0;
            else if (cnt == LAST) begin
                level <= sync[1];
                fall  <= level;
                cnt   <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with ACK/NACK/timeout reporting.
// Define PS2_TX_RETRY_EN to retry a failed byte up to MAX_RETRY times before reporting.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES       = 6000,
    parameter int START_TIMEOUT_CYCLES = 750000,
    parameter int XFER_TIMEOUT_CYCLES  = 100000,
    parameter int FILTER_LEN           = 8,
    parameter int MAX_RETRY            = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       kclk_in,
    input  logic       kdata_in,
    output logic       kclk_oe,
    output logic       kdata_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic [1:0] err_code
);
    localparam int TMAX = INHIBIT_CYCLES > START_TIMEOUT_CYCLES ? INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    localparam int XW = $clog2(XFER_TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] INH_START = TW'(INHIBIT_CYCLES - 2);
    localparam logic [TW-1:0] INH_END   = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] START_END = TW'(START_TIMEOUT_CYCLES - 1);
    localparam logic [XW-1:0] XFER_END  = XW'(XFER_TIMEOUT_CYCLES - 1);

    state_t state;
    logic [7:0] data;
    logic par;
    logic [TW-1:0] tmr;
    logic [XW-1:0] xtmr;
    logic [3:0] cnt;
    logic clk_lvl, clk_fall, dat_lvl, dat_fall_unused;
    logic xfer_to, start_to, nack, fail_req;
    logic [1:0] fail_code;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk(clk), .rst(rst), .raw(kclk_in), .level(clk_lvl), .fall(clk_fall)
    );
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk(clk), .rst(rst), .raw(kdata_in), .level(dat_lvl), .fall(dat_fall_unused)
    );

`ifdef PS2_TX_RETRY_EN
    localparam int RW = $clog2(MAX_RETRY + 2);
    logic [RW-1:0] retry;
    logic retry_ok;
    assign retry_ok = retry < RW'(MAX_RETRY);
`else
    localparam int MAX_RETRY_UNUSED = MAX_RETRY;
`endif

    // A transfer timeout outranks any line event seen on the same cycle
    always_comb begin
        xfer_to   = (state == SHIFT || state == ACK || state == FINISH) && xtmr == XFER_END;
        start_to  = state == WAIT_START && tmr == START_END && !clk_fall;
        nack      = state == ACK && clk_fall && dat_lvl && !xfer_to;
        fail_code = xfer_to ? ERR_XFER_TO : nack ? ERR_NACK : ERR_START_TO;
    end
    assign fail_req = xfer_to | start_to | nack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            data     <= '0;
            par      <= 1'b0;
            tmr      <= '0;
            xtmr     <= '0;
            cnt      <= '0;
            kclk_oe  <= 1'b0;
            kdata_oe <= 1'b0;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
            done     <= 1'b0;
            ack_ok   <= 1'b0;
            err_code <= ERR_NONE;
`ifdef PS2_TX_RETRY_EN
            retry    <= '0;
`endif
        end else begin
            done <= 1'b0;
            tmr  <= tmr == '1 ? tmr : tmr + 1'b1;
            xtmr <= xtmr == '1 ? xtmr : xtmr + 1'b1;
            case (state)
                IDLE: if (tx_valid && tx_ready) begin
                    data     <= tx_data;
                    par      <= odd_parity(tx_data);
                    state    <= INHIBIT;
                    kclk_oe  <= 1'b1;
                    tmr      <= '0;
                    busy     <= 1'b1;
                    tx_ready <= 1'b0;
                    ack_ok   <= 1'b0;
                    err_code <= ERR_NONE;
`ifdef PS2_TX_RETRY_EN
                    retry    <= '0;
`endif
                end
                // Start bit goes out one cycle before kclk is released
                INHIBIT: begin
                    if (tmr == INH_START) kdata_oe <= 1'b1;
                    if (tmr == INH_END) begin
                        kclk_oe <= 1'b0;
                        state   <= WAIT_START;
                        tmr     <= '0;
                    end
                end
                WAIT_START: if (clk_fall) begin
                    kdata_oe <= ~data[0];
                    cnt      <= 4'd1;
                    xtmr     <= '0;
                    state    <= SHIFT;
                end
                SHIFT: if (clk_fall) begin
                    kdata_oe <= cnt == 4'd8 ? ~par : cnt == 4'd9 ? 1'b0 : ~data[cnt[2:0]];
                    cnt      <= cnt + 1'b1;
                    if (cnt == 4'd9) state <= ACK;
                end
                ACK: if (clk_fall && !dat_lvl) state <= FINISH;
                FINISH: if (clk_lvl && dat_lvl && !xfer_to) begin
                    done     <= 1'b1;
                    ack_ok   <= 1'b1;
                    err_code <= ERR_NONE;
                    busy     <= 1'b0;
                    tx_ready <= 1'b1;
                    state    <= IDLE;
                end
                FAIL: begin
                    done     <= 1'b1;
                    ack_ok   <= 1'b0;
                    busy     <= 1'b0;
                    tx_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (fail_req) begin
                err_code <= fail_code;
                kdata_oe <= 1'b0;
                tmr      <= '0;
`ifdef PS2_TX_RETRY_EN
                if (retry_ok) begin
                    retry   <= retry + 1'b1;
                    kclk_oe <= 1'b1;
                    state   <= INHIBIT;
                end else begin
                    kclk_oe <= 1'b0;
                    state   <= FAIL;
                end
`else
                kclk_oe <= 1'b0;
                state   <= FAIL;
`endif
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with an open-drain PS/2 device model for ps2_host_tx.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 60, STO = 300, XTO = 1500, FL = 8, H = 40;

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic [9:0] bits;
        logic       ok;
        logic [1:0] err;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, tx_valid = 1'b0, dev_clk = 1'b1, dev_dat = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic tx_ready, kclk_oe, kdata_oe, busy, done, ack_ok;
    logic [1:0] err_code;
    logic kclk_line, kdata_line;
    int total = 0, bad = 0, cyc = 0, done_cnt = 0, done_cyc = 0, inh_cnt = 0;
    logic last_ack = 1'b0, prev_kclk_oe = 1'b0;
    logic [1:0] last_err = 2'd0;

    assign kclk_line  = dev_clk & ~kclk_oe;
    assign kdata_line = dev_dat & ~kdata_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH), .START_TIMEOUT_CYCLES(STO), .XFER_TIMEOUT_CYCLES(XTO),
        .FILTER_LEN(FL), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .kclk_in(kclk_line), .kdata_in(kdata_line), .kclk_oe(kclk_oe), .kdata_oe(kdata_oe),
        .busy(busy), .done(done), .ack_ok(ack_ok), .err_code(err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_kclk_oe <= kclk_oe;
        if (kclk_oe && !prev_kclk_oe) inh_cnt <= inh_cnt + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            last_ack <= ack_ok;
            last_err <= err_code;
            done_cyc <= cyc;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send_measure(input logic [7:0] d, output int n, output int t_rel);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("ready_drop", tx_ready, 0);
        check("busy_rise", busy, 1);
        n = 0;
        while (kclk_oe && n < INH + 100) begin
            n++;
            @(negedge clk);
        end
        t_rel = cyc;
        check("start_bit", kdata_oe, 1);
    endtask

    task automatic dev_run(input int nf, input logic ack, output logic [9:0] bits, output int t_first);
        int w = 0;
        bits = '0;
        t_first = 0;
        while (kclk_oe && w < 1000) begin
            w++;
            @(negedge clk);
        end
        check("rts_release", kclk_oe, 0);
        repeat (20) @(negedge clk);
        for (int i = 1; i <= nf; i++) begin
            if (i == 11) begin
                repeat (H / 2) @(negedge clk);
                dev_dat = ~ack;
                repeat (H / 2) @(negedge clk);
            end else
                repeat (H) @(negedge clk);
            dev_clk = 1'b0;
            if (i == 1) t_first = cyc;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            if (i <= 10) bits[i-1] = kdata_line;
        end
        dev_dat = 1'b1;
    endtask

    task automatic wait_done(input int c0, input int lim);
        int n = 0;
        while (done_cnt == c0 && n < lim) begin
            n++;
            @(negedge clk);
        end
        @(negedge clk);
        check("done_seen", done_cnt, c0 + 1);
    endtask

    initial begin
        vec_t vecs[5];
        int n, t, tf, c0, i0;
        logic [9:0] b;
        vecs[0] = '{CMD_SET_LEDS, 1'b1, 10'b1_1_11101101, 1'b1, ERR_NONE};
        vecs[1] = '{8'h00,        1'b1, 10'b1_1_00000000, 1'b1, ERR_NONE};
        vecs[2] = '{8'h01,        1'b1, 10'b1_0_00000001, 1'b1, ERR_NONE};
        vecs[3] = '{CMD_ECHO,     1'b1, 10'b1_1_11101110, 1'b1, ERR_NONE};
        vecs[4] = '{CMD_RESET,    1'b1, 10'b1_1_11111111, 1'b1, ERR_NONE};

        repeat (3) @(negedge clk);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_kclk_oe", kclk_oe, 0);
        check("rst_kdata_oe", kdata_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_ok", ack_ok, 0);
        check("rst_err", err_code, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            c0 = done_cnt;
            i0 = inh_cnt;
            send_measure(vecs[k].data, n, t);
            check("inhibit_len", n, INH);
            tx_data  = 8'h55;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            dev_run(11, vecs[k].ack, b, tf);
            check("frame_bits", b, vecs[k].bits);
            wait_done(c0, 2000);
            check("ack_ok", last_ack, vecs[k].ok);
            check("err_code", last_err, vecs[k].err);
            check("busy_after", busy, 0);
            check("ready_after", tx_ready, 1);
            check("oe_after", {kclk_oe, kdata_oe}, 0);
            repeat (20) @(negedge clk);
            check("single_inhibit", inh_cnt - i0, 1);
            check("single_done", done_cnt, c0 + 1);
        end

        c0 = done_cnt;
        i0 = inh_cnt;
        send_measure(CMD_RESEND, n, t);
`ifdef PS2_TX_RETRY_EN
        for (int k = 0; k < 3; k++) dev_run(11, k == 2, b, tf);
        wait_done(c0, 3000);
        check("retry_ack", last_ack, 1);
        check("retry_err", last_err, ERR_NONE);
        repeat (20) @(negedge clk);
        check("retry_inhibits", inh_cnt - i0, 3);
        check("retry_single_done", done_cnt, c0 + 1);
`else
        dev_run(11, 1'b0, b, tf);
        check("nack_bits", b, 10'b1_0_11111110);
        wait_done(c0, 2000);
        check("nack_ack", last_ack, 0);
        check("nack_err", last_err, ERR_NACK);
        check("nack_oe", {kclk_oe, kdata_oe}, 0);
`endif

        c0 = done_cnt;
        send_measure(CMD_ENABLE, n, t);
        wait_done(c0, 5000);
        check("sto_ack", last_ack, 0);
        check("sto_err", last_err, ERR_START_TO);
        check("sto_oe", {kclk_oe, kdata_oe}, 0);
`ifndef PS2_TX_RETRY_EN
        check("sto_time", done_cyc - t, STO + 1);
`endif

        c0 = done_cnt;
        send_measure(CMD_SET_LEDS, n, t);
        dev_run(5, 1'b1, b, tf);
        check("xto_partial_bits", b[4:0], 5'b01101);
        wait_done(c0, 6000);
        check("xto_ack", last_ack, 0);
        check("xto_oe", {kclk_oe, kdata_oe}, 0);
`ifdef PS2_TX_RETRY_EN
        check("xto_err", last_err, ERR_START_TO);
`else
        check("xto_err", last_err, ERR_XFER_TO);
        check("xto_time", done_cyc - tf, XTO + 12);
`endif

        c0 = done_cnt;
        send_measure(8'h12, n, t);
        dev_run(4, 1'b1, b, tf);
        check("pre_rst_kdata", kdata_oe, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_kclk_oe", kclk_oe, 0);
        check("midrst_kdata_oe", kdata_oe, 0);
        check("midrst_ready", tx_ready, 1);
        check("midrst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_no_done", done_cnt, c0);

        c0 = done_cnt;
        send_measure(CMD_ENABLE, n, t);
        check("post_rst_inhibit", n, INH);
        dev_run(11, 1'b1, b, tf);
        check("post_rst_bits", b, 10'b1_0_11110100);
        wait_done(c0, 2000);
        check("post_rst_ack", last_ack, 1);
        check("post_rst_err", last_err, ERR_NONE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
